// File: rtl/gsim_band_mult.sv
`default_nettype none
// ============================================================================
// Module   : gsim_band_mult
// Purpose  : Forward banded mat-vec b = A*x for the GSIM 16x16 band matrix
//            (20, -13, 6, -1), regenerating b from the solver's x stream.
// Revision : 1.0 - initial release
// ============================================================================
module gsim_band_mult #(
    parameter int N    = 16,
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_en,
    input  logic [DW-1:0] x_in,
    output logic          b_valid,
    output logic [DW+5:0] b_out,
    output logic [15:0]   b_int,
    output logic          done
);

    localparam int c_BW = DW + 6;
    localparam int c_QW = c_BW + 1 - FRAC;
    localparam int c_CW = $clog2(N + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [c_CW-1:0]        count_q, count_d;
    logic [1:0]             flush_q, flush_d;
    logic signed [DW-1:0]   w_q [7];
    logic signed [DW-1:0]   w_d [7];
    logic                   pend_q, pend_d;
    logic                   last_q, last_d;
    logic                   b_valid_q, b_valid_d;
    logic [c_BW-1:0]        b_out_q, b_out_d;
    logic [15:0]            b_int_q, b_int_d;
    logic                   done_q, done_d;

    logic                   w_shift;
    logic signed [DW-1:0]   w_shin;
    logic signed [c_BW-1:0] w_e [7];
    logic signed [c_BW-1:0] w_p24, w_p15, w_p06, w_sum;
    logic signed [c_BW:0]   w_t;
    logic [c_QW-1:0]        w_q16;
    logic [15:0]            w_sat;

    // Row sum on the window as it stands before the edge that registers b[i].
    always_comb begin
        for (int j = 0; j < 7; j++) begin
            w_e[j] = {{(c_BW-DW){w_q[j][DW-1]}}, w_q[j]};
        end
        w_p24 = w_e[2] + w_e[4];
        w_p15 = w_e[1] + w_e[5];
        w_p06 = w_e[0] + w_e[6];
        w_sum = (w_e[3] <<< 4) + (w_e[3] <<< 2)
              - ((w_p24 <<< 3) + (w_p24 <<< 2) + w_p24)
              + (w_p15 <<< 2) + (w_p15 <<< 1)
              - w_p06;
        w_t   = {w_sum[c_BW-1], w_sum} + ({{c_BW{1'b0}}, 1'b1} <<< (FRAC - 1));
        w_q16 = w_t[c_BW:FRAC];
        if ((&w_q16[c_QW-1:15]) || ~(|w_q16[c_QW-1:15])) begin
            w_sat = w_q16[15:0];
        end else if (w_q16[c_QW-1]) begin
            w_sat = 16'h8000;
        end else begin
            w_sat = 16'h7FFF;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        flush_d   = flush_q;
        w_d       = w_q;
        w_shift   = 1'b0;
        w_shin    = x_in;
        pend_d    = 1'b0;
        last_d    = 1'b0;
        b_valid_d = pend_q;
        done_d    = last_q;
        b_out_d   = b_out_q;
        b_int_d   = b_int_q;

        case (state_q)
            c_IDLE: begin
                if (in_en) begin
                    w_shift = 1'b1;
                    count_d = c_CW'(1);
                    state_d = c_LOAD;
                end
            end
            c_LOAD: begin
                if (in_en) begin
                    w_shift = 1'b1;
                    count_d = count_q + c_CW'(1);
                    pend_d  = (count_q >= c_CW'(3));
                    if (count_q == c_CW'(N - 1)) begin
                        state_d = c_FLUSH;
                        flush_d = 2'd0;
                    end
                end
            end
            c_FLUSH: begin
                w_shift = 1'b1;
                w_shin  = '0;
                pend_d  = 1'b1;
                flush_d = flush_q + 2'd1;
                if (flush_q == 2'd2) begin
                    last_d  = 1'b1;
                    state_d = c_DONE;
                end
            end
            default: begin
                state_d = c_IDLE;
                count_d = '0;
                for (int j = 0; j < 7; j++) begin
                    w_d[j] = '0;
                end
            end
        endcase

        if (w_shift) begin
            for (int j = 0; j < 6; j++) begin
                w_d[j] = w_q[j+1];
            end
            w_d[6] = w_shin;
        end

        if (pend_q) begin
            b_out_d = w_sum;
            b_int_d = w_sat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= c_IDLE;
            count_q   <= '0;
            flush_q   <= '0;
            for (int j = 0; j < 7; j++) begin
                w_q[j] <= '0;
            end
            pend_q    <= 1'b0;
            last_q    <= 1'b0;
            b_valid_q <= 1'b0;
            b_out_q   <= '0;
            b_int_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            flush_q   <= flush_d;
            w_q       <= w_d;
            pend_q    <= pend_d;
            last_q    <= last_d;
            b_valid_q <= b_valid_d;
            b_out_q   <= b_out_d;
            b_int_q   <= b_int_d;
            done_q    <= done_d;
        end
    end

    assign b_valid = b_valid_q;
    assign b_out   = b_out_q;
    assign b_int   = b_int_q;
    assign done    = done_q;

endmodule
`default_nettype wire
